// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: oversampling-free UART receiver (mid-bit sampling) feeding a first-word-fall-through FIFO.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_en_i,
  input  logic       rx_bit_i,
  input  logic       rx_re_i,
  output logic [7:0] dout_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LD   = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD   = CW'(BAUD_DIV - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Synchronizer; the third flop only provides the previous value for edge detection.
  logic sync1_q, sync2_q, rxs_prev_q;
  logic rxs;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx_bit_i;
      sync2_q    <= sync1_q;
      rxs_prev_q <= sync2_q;
    end
  end

  assign rxs = sync2_q;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          push_req_q;
  logic          frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q;
  logic          parity_err_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      push_req_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      push_req_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (!rx_en_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rxs_prev_q && !rxs) begin
              state_q <= S_START;
              cnt_q   <= HALF_LD;
            end
          end
          S_START: begin
            if (cnt_q == '0) begin
              if (!rxs) begin
                state_q   <= S_DATA;
                cnt_q     <= FULL_LD;
                bit_idx_q <= 3'd0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          S_DATA: begin
            if (cnt_q == '0) begin
              shift_q   <= {rxs, shift_q[7:1]};
              cnt_q     <= FULL_LD;
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (cnt_q == '0) begin
              // Even parity: the parity bit must equal the XOR of the data bits.
              par_bad_q <= rxs ^ (^shift_q);
              cnt_q     <= FULL_LD;
              state_q   <= S_STOP;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
`endif
          S_STOP: begin
            if (cnt_q == '0) begin
              state_q <= S_IDLE;
              if (!rxs) begin
                frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (par_bad_q) begin
                parity_err_q <= 1'b1;
`endif
              end else begin
                push_req_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign frame_err_o = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  // Receive FIFO. The head byte is registered, with a bypass when the write lands on the new head.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    dout_q, dout_d;
  logic          overrun_q;
  logic          is_full, pop, push, overrun_d;

  assign is_full   = (count_q == DEPTH_CNT);
  assign pop       = rx_re_i && (count_q != '0);
  assign push      = push_req_q && (!is_full || pop);
  assign overrun_d = push_req_q && is_full && !pop;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW + 1)'(1);
    end
    dout_d = 8'h00;
    if (count_d != '0) begin
      dout_d = (push && (wr_ptr_q == rd_ptr_d)) ? shift_q : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dout_q    <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dout_q    <= dout_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout_o    = dout_q;
  assign empty_o   = (count_q == '0);
  assign full_o    = is_full;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: directed frames against a queue-based receiver model with per-cycle output checks.
module tb_uart_rx;

  localparam int BAUD  = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, rx_en, rx_bit, rx_re;
  logic [7:0] dout;
  logic       empty, full, frame_err, overrun, parity_err;

  uart_rx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_en_i     (rx_en),
    .rx_bit_i    (rx_bit),
    .rx_re_i     (rx_re),
    .dout_o      (dout),
    .empty_o     (empty),
    .full_o      (full),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .parity_err_o(parity_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] model_q[$];
  bit         cmp_en = 1'b0;
  bit         window = 1'b0;
  int         fe_cnt, pe_cnt, ov_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Outside a stop-bit window the FIFO view must match the model and no flag may pulse;
  // inside the window, pulses are only counted and judged when the frame ends.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        if (window) begin
          fe_cnt += int'(frame_err);
          pe_cnt += int'(parity_err);
          ov_cnt += int'(overrun);
        end else begin
          chk("empty", 32'(empty), 32'(model_q.size() == 0));
          chk("full", 32'(full), 32'(model_q.size() == DEPTH));
          if (model_q.size() != 0) chk("dout", 32'(dout), 32'(model_q[0]));
          chk("frame_err_quiet", 32'(frame_err), 32'd0);
          chk("parity_err_quiet", 32'(parity_err), 32'd0);
          chk("overrun_quiet", 32'(overrun), 32'd0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // drop_bit >= 0: rx_en falls mid-way through that frame bit (0 = start bit); the frame must vanish.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_ok,
                            input int drop_bit);
    logic [10:0] bits;
    bit exp_fe, exp_pe, exp_ov;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^b) ^ ~par_ok;
    bits[10] = stop_b;
`else
    bits[9]  = stop_b;
`endif
    for (int i = 0; i < NBITS; i++) begin
      if (i == NBITS - 1 && drop_bit < 0) begin
        fe_cnt = 0;
        pe_cnt = 0;
        ov_cnt = 0;
        window = 1'b1;
      end
      rx_bit = bits[0];
      bits   = bits >> 1;
      for (int c = 0; c < BAUD; c++) begin
        if (i == drop_bit && c == BAUD / 2) rx_en = 1'b0;
        @(negedge clk);
      end
    end
    rx_bit = 1'b1;
    if (drop_bit < 0) begin
      exp_fe = !stop_b;
      exp_pe = PAR && stop_b && !par_ok;
      exp_ov = !exp_fe && !exp_pe && (model_q.size() == DEPTH);
      chk("frame_err_pulses", 32'(fe_cnt), 32'(exp_fe));
      chk("parity_err_pulses", 32'(pe_cnt), 32'(exp_pe));
      chk("overrun_pulses", 32'(ov_cnt), 32'(exp_ov));
      if (!exp_fe && !exp_pe && !exp_ov) model_q.push_back(b);
      window = 1'b0;
      $display("frame %02h stop=%0d par_ok=%0d -> fe=%0d pe=%0d ov=%0d depth=%0d",
               b, stop_b, par_ok, fe_cnt, pe_cnt, ov_cnt, model_q.size());
    end else begin
      $display("frame %02h aborted by rx_en at bit %0d", b, drop_bit);
    end
  endtask

  task automatic pop_expect(input logic [7:0] lit);
    chk("pop_head", 32'(dout), 32'(lit));
    rx_re = 1'b1;
    if (model_q.size() != 0) void'(model_q.pop_front());
    @(negedge clk);
    rx_re = 1'b0;
    $display("pop %02h depth=%0d", lit, model_q.size());
  endtask

  initial begin
    rst = 1'b1; rx_en = 1'b1; rx_bit = 1'b1; rx_re = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_dout", 32'(dout), 32'h00);
    chk("reset_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    idle(20);

    // Four back-to-back frames fill the four-entry FIFO, then drain in order.
    send_frame(8'h41, 1'b1, 1'b1, -1);
    send_frame(8'h42, 1'b1, 1'b1, -1);
    send_frame(8'h43, 1'b1, 1'b1, -1);
    send_frame(8'h0A, 1'b1, 1'b1, -1);
    chk("head_41", 32'(dout), 32'h41);
    chk("full_after_four", 32'(full), 32'd1);
    pop_expect(8'h41);
    pop_expect(8'h42);
    pop_expect(8'h43);
    pop_expect(8'h0A);
    idle(2);
    chk("empty_after_drain", 32'(empty), 32'd1);

    // A read on an empty FIFO must not disturb pointers or count.
    rx_re = 1'b1;
    idle(1);
    rx_re = 1'b0;
    idle(4);
    send_frame(8'h99, 1'b1, 1'b1, -1);
    pop_expect(8'h99);

    // Short low glitch on an idle line.
    rx_bit = 1'b0;
    idle(4);
    rx_bit = 1'b1;
    idle(60);
    chk("glitch_no_push", 32'(empty), 32'd1);

    // Framing error, then a good frame after the line idles high.
    send_frame(8'h55, 1'b0, 1'b1, -1);
    chk("frame_err_literal", 32'(fe_cnt), 32'd1);
    idle(20);
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    pop_expect(8'hA5);
    idle(4);

    // Five frames with no reads: fifth is dropped as an overrun.
    send_frame(8'h11, 1'b1, 1'b1, -1);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    send_frame(8'h33, 1'b1, 1'b1, -1);
    send_frame(8'h44, 1'b1, 1'b1, -1);
    chk("full_literal", 32'(full), 32'd1);
    send_frame(8'h5A, 1'b1, 1'b1, -1);
    chk("overrun_literal", 32'(ov_cnt), 32'd1);
    chk("head_first_byte", 32'(dout), 32'h11);
    pop_expect(8'h11);
    pop_expect(8'h22);
    pop_expect(8'h33);
    pop_expect(8'h44);
    idle(4);

    // Receiver disabled during data bit 3, re-enabled on an idle line.
    send_frame(8'hFF, 1'b1, 1'b1, 4);
    idle(20);
    rx_en = 1'b1;
    idle(20);
    chk("disable_no_push", 32'(empty), 32'd1);
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    pop_expect(8'h3C);
    idle(4);

    // Reset mid-frame with a read strobe and FIFO contents.
    send_frame(8'h01, 1'b1, 1'b1, -1);
    send_frame(8'h02, 1'b1, 1'b1, -1);
    rx_bit = 1'b0;
    idle(BAUD * 3);
    rst = 1'b1;
    rx_re = 1'b1;
    rx_bit = 1'b1;
    model_q.delete();
    @(negedge clk);
    chk("midframe_reset_empty", 32'(empty), 32'd1);
    chk("midframe_reset_dout", 32'(dout), 32'h00);
    rst = 1'b0;
    rx_re = 1'b0;
    idle(200);
    send_frame(8'h6D, 1'b1, 1'b1, -1);
    pop_expect(8'h6D);
    idle(4);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, -1);
    chk("parity_err_literal", 32'(pe_cnt), 32'd1);
    idle(4);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    pop_expect(8'h07);
    idle(4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_DIV, default 868, clk_i cycles per UART bit; legal values >= 4.
REQ-002 Parameter FIFO_DEPTH, default 16, receive FIFO entries; power of 2, >= 2.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 rx_en_i  input  1  receiver enable; low holds the FSM in IDLE.
REQ-006 rx_bit_i  input  1  asynchronous serial line; idle high.
REQ-007 rx_re_i  input  1  FIFO read strobe; pops the head entry.
REQ-008 dout_o  output  8  FIFO head byte, first-word-fall-through.
REQ-009 empty_o  output  1  FIFO holds zero entries.
REQ-010 full_o  output  1  FIFO holds FIFO_DEPTH entries.
REQ-011 frame_err_o  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-012 overrun_o  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-013 parity_err_o  output  1  one-cycle pulse when the parity check fails; constant 0 without UART_RX_PARITY_EN.

Function
REQ-014 rx_bit_i passes a 2-flop synchronizer; all FSM decisions use the synchronized bit (rxs).
REQ-015 FSM states: IDLE, START, DATA, [PARITY], STOP; one baud counter and one 3-bit bit index.
REQ-016 IDLE -> START on rxs falling edge (previous 1, current 1->0) with rx_en_i high; the baud counter loads BAUD_DIV/2-1.
REQ-017 START at counter 0: rxs==0 -> DATA with counter BAUD_DIV-1; rxs==1 -> IDLE (glitch reject, no flags).
REQ-018 DATA samples rxs at each counter 0, LSB first, into the shift register; after bit 7 -> PARITY if enabled, else STOP.
REQ-019 STOP samples at counter 0, mid stop bit, then returns to IDLE the next cycle, so back-to-back frames are supported.
REQ-020 Stop==1 and no parity error: push the byte if the FIFO is not full, else pulse overrun_o and drop the byte.
REQ-021 Stop==0: pulse frame_err_o, discard the byte; IDLE re-arms only after rxs is seen high.
REQ-022 Push occurs in the cycle after the stop sample; empty_o deasserts and dout_o is valid the following cycle.
REQ-023 rx_re_i with empty_o high is ignored; pointers and count are unchanged.
REQ-024 Simultaneous push and pop: count unchanged and both succeed, including when the FIFO is full (no overrun).
REQ-025 Read and write pointers wrap modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits wide.
REQ-026 rx_en_i deasserted mid-frame: FSM -> IDLE next cycle, partial byte discarded, no flags; FIFO reads unaffected.
REQ-027 Error pulses are mutually exclusive per frame; priority is frame_err_o > parity_err_o > overrun_o.

Reset
REQ-028 rst_i high at a clock edge: FSM=IDLE, counters=0, FIFO pointers and count=0, synchronizer flops=1.
REQ-029 Output values while in reset: empty_o=1, full_o=0, dout_o=8'h00, all error pulses 0.
REQ-030 Reset asserted mid-frame discards the frame and all FIFO contents, and reset takes priority over rx_re_i.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: the PARITY state samples one even-parity bit after the data bits.
REQ-032 With the macro, a mismatch pulses parity_err_o and discards the byte (no push); the frame is 11 bits.
REQ-033 Without the macro: no PARITY state, 10-bit frame, parity_err_o tied 0.

Verification
REQ-034 BAUD_DIV=16: frames 'h41,'h42,'h43,'h0A sent back-to-back (start, LSB first, stop) -> four pushes, then four rx_re_i pops return 41,42,43,0A in order, and empty_o=1 after the last pop.
REQ-035 Low glitch of 4 cycles on an idle line -> FSM back in IDLE, no push, no flags.
REQ-036 Frame 'h55 with stop bit=0 -> frame_err_o one pulse, FIFO stays empty; a following good 'hA5 is received.
REQ-037 FIFO_DEPTH=4: five frames without reads -> full_o=1 after the fourth, overrun_o pulses on the fifth, head byte = first byte.
REQ-038 rx_en_i dropped at data bit 3 of 'hFF, then re-enabled -> no push; the next frame 'h3C is received correctly.
REQ-039 With UART_RX_PARITY_EN: 'h07 sent with parity bit 0 -> parity_err_o pulse, no push; sent with parity bit 1 -> pushed.
